// File: rtl/sel_pkg.sv
// Shared encodings and widths for the round-robin select arbiter.
package sel_pkg;
   localparam int NUM_REQ = 4;
   localparam int SEL_W   = 2;
   localparam int CNT_W   = 8;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;
endpackage

// File: rtl/rr_pick.sv
// Rotating priority picker: first set req bit at or after start, wrapping 3->0.
// Latency: combinational.
// Backpressure: none; pure function of req and start.
module rr_pick
   import sel_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [SEL_W-1:0]   start,
   output logic [SEL_W-1:0]   index,
   output logic               found
);

   logic [2*NUM_REQ-1:0] req_dbl;
   logic [NUM_REQ-1:0]   req_rot;
   logic [SEL_W-1:0]     offset;

   always_comb begin
      req_dbl = {req, req} >> start;
      req_rot = req_dbl[NUM_REQ-1:0];
      offset  = '0;
      // Scan downward so the lowest rotated position wins.
      for (int i = NUM_REQ-1; i >= 0; i--) begin
         if (req_rot[i]) offset = SEL_W'(i);
      end
      index = start + offset;
      found = |req;
   end

endmodule

// File: rtl/rr_sel_arbiter.sv
// Four-way round-robin arbiter driving a registered 2-bit decoder select.
// Latency: one cycle from sampled req to sel/sel_valid; back-to-back grants with no dead cycle.
// Backpressure: none; RR_ARB_TIMEOUT_EN enables forced rotation after MAX_HOLD cycles.
module rr_sel_arbiter
   import sel_pkg::*;
#(
   parameter int MAX_HOLD = 8
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   output logic [SEL_W-1:0]   sel,
   output logic               sel_valid,
   output logic [CNT_W-1:0]   hold_cnt
);

`ifdef RR_ARB_TIMEOUT_EN
   localparam logic TIMEOUT_EN = 1'b1;
`else
   localparam logic TIMEOUT_EN = 1'b0;
`endif

   logic [0:0]         state;
   logic [SEL_W-1:0]   last;
   logic [NUM_REQ-1:0] sel_oh;
   logic               req_cur;
   logic               others_req;
   logic               timeout_hit;
   logic               rotate;
   logic [SEL_W-1:0]   pick_idx;
   logic               pick_found;

   // In GRANT, last equals sel, so last+1 is also the post-release search start.
   rr_pick u_pick (
      .req   (req),
      .start (last + SEL_W'(1)),
      .index (pick_idx),
      .found (pick_found)
   );

   always_comb begin
      sel_oh      = NUM_REQ'(1) << sel;
      req_cur     = |(req & sel_oh);
      others_req  = |(req & ~sel_oh);
      timeout_hit = TIMEOUT_EN && req_cur && (hold_cnt == CNT_W'(MAX_HOLD - 1));
      rotate      = others_req && (!req_cur || timeout_hit);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         sel       <= '0;
         sel_valid <= 1'b0;
         hold_cnt  <= '0;
         last      <= SEL_W'(NUM_REQ - 1);
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_found) begin
                  state     <= ST_GRANT;
                  sel       <= pick_idx;
                  sel_valid <= 1'b1;
                  hold_cnt  <= '0;
                  last      <= pick_idx;
               end
            end
            default: begin
               if (rotate) begin
                  sel      <= pick_idx;
                  last     <= pick_idx;
                  hold_cnt <= '0;
               end else if (!req_cur) begin
                  state     <= ST_IDLE;
                  sel_valid <= 1'b0;
                  hold_cnt  <= '0;
               end else if (hold_cnt != '1) begin
                  hold_cnt <= hold_cnt + CNT_W'(1);
               end
            end
         endcase
      end
   end

endmodule
